// File: rtl/ov7670_frame_capture.sv
// OV7670 DVP capture: armed, frame-synchronised pixel capture into a frame-buffer write port.
// Unpacks RGB565 to RGB888 or YUV422 to grayscale, with integer decimation and frame status pulses.
module ov7670_frame_capture #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int DECIM      = 1,
    localparam int OUT_W      = IMG_WIDTH / DECIM,
    localparam int OUT_H      = IMG_HEIGHT / DECIM,
    localparam int ADDR_WIDTH = $clog2(OUT_W * OUT_H)
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  continuous,
    input  logic                  fmt,
    input  logic                  href,
    input  logic                  vsync,
    input  logic [7:0]            data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wAddr,
    output logic [23:0]           wData,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err
);
    localparam int TOTAL = OUT_W * OUT_H;
    localparam int XW    = $clog2(IMG_WIDTH + 1);
    localparam int YW    = $clog2(IMG_HEIGHT + 1);
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [XW-1:0] X_LIM  = XW'(IMG_WIDTH);
    localparam logic [YW-1:0] Y_LIM  = YW'(IMG_HEIGHT);
    localparam logic [CW-1:0] C_LIM  = CW'(TOTAL);
    localparam logic [XW-1:0] X_MASK = XW'(DECIM - 1);
    localparam logic [YW-1:0] Y_MASK = YW'(DECIM - 1);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

    state_t          state, state_nx;
    logic            vs_q, vs_q2, hs_q, hs_q2;
    logic [7:0]      data_q, hi;
    logic            tog, cont_l, fmt_l, ovf;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   count;
    logic            vs_fall, vs_rise, hs_fall;
    logic            phase_hit, in_window;
    logic [23:0]     pix;

    assign vs_fall = vs_q2 & ~vs_q;
    assign vs_rise = ~vs_q2 & vs_q;
    assign hs_fall = hs_q2 & ~hs_q;

    // Decimation phase and window are judged on the pixel's own coordinates (pre-increment x).
    assign phase_hit = ((x & X_MASK) == '0) && ((y & Y_MASK) == '0);
    assign in_window = (x < X_LIM) && (y < Y_LIM) && (count < C_LIM);

    assign pix = fmt_l ? {hi, hi, hi}
                       : {hi[7:3], 3'b000, hi[2:0], data_q[7:5], 2'b00, data_q[4:0], 3'b000};

    always_ff @(posedge pclk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE: if (arm) state_nx = WAIT_VS;
            WAIT_VS: begin
                busy = 1'b1;
                if (vs_fall) state_nx = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (vs_rise) state_nx = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                frame_err  = ovf || (count != C_LIM);
                state_nx   = cont_l ? WAIT_VS : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            vs_q   <= 1'b0;
            vs_q2  <= 1'b0;
            hs_q   <= 1'b0;
            hs_q2  <= 1'b0;
            data_q <= '0;
            hi     <= '0;
            tog    <= 1'b0;
            cont_l <= 1'b0;
            fmt_l  <= 1'b0;
            ovf    <= 1'b0;
            x      <= '0;
            y      <= '0;
            count  <= '0;
            we     <= 1'b0;
            wAddr  <= '0;
            wData  <= '0;
        end else begin
            vs_q   <= vsync;
            vs_q2  <= vs_q;
            hs_q   <= href;
            hs_q2  <= hs_q;
            data_q <= data;
            we     <= 1'b0;

            if (state == IDLE && arm)
                cont_l <= continuous;

            // Address advances after each accepted write and parks on the last slot.
            if (we && count != C_LIM)
                wAddr <= wAddr + ADDR_WIDTH'(1);

            if (state == WAIT_VS && vs_fall) begin
                fmt_l <= fmt;
                tog   <= 1'b0;
                ovf   <= 1'b0;
                x     <= '0;
                y     <= '0;
                count <= '0;
                wAddr <= '0;
            end

            // A vsync rise aborts any line in flight; DONE then clears the line state.
            if (state == CAPTURE && !vs_rise) begin
                if (hs_q) begin
                    if (!tog) begin
                        hi  <= data_q;
                        tog <= 1'b1;
                    end else begin
                        tog <= 1'b0;
                        if (x < X_LIM) x <= x + XW'(1);
                        if (phase_hit) begin
                            if (in_window) begin
                                we    <= 1'b1;
                                wData <= pix;
                                count <= count + CW'(1);
                            end else begin
                                ovf <= 1'b1;
                            end
                        end
                    end
                end else if (hs_fall) begin
                    tog <= 1'b0;
                    x   <= '0;
                    if (x != '0 && y < Y_LIM) y <= y + YW'(1);
                end
            end

            if (state == DONE) begin
                tog   <= 1'b0;
                ovf   <= 1'b0;
                x     <= '0;
                y     <= '0;
                count <= '0;
                wAddr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Scoreboard bench: two capture engines (4x2 /1 and 8x4 /2) share one sensor bus.
// Expected writes and frame-status results are queued as bytes are driven and popped on DUT output.
module tb_ov7670_frame_capture;
    localparam int W1 = 4, H1 = 2, D1 = 1;
    localparam int W2 = 8, H2 = 4, D2 = 2;

    logic pclk = 1'b0;
    logic reset, fmt, href, vsync;
    logic [7:0] data;
    logic arm1, cont1, arm2, cont2;
    logic we1, busy1, frame_done1, frame_err1;
    logic we2, busy2, frame_done2, frame_err2;
    logic [2:0]  wAddr1, wAddr2;
    logic [23:0] wData1, wData2;

    int n_chk = 0;
    int n_pass = 0;

    logic [55:0] q1[$], q2[$];
    bit          dq1[$], dq2[$];
    logic [55:0] e1, e2;

    always #5 pclk = ~pclk;

    ov7670_frame_capture #(.IMG_WIDTH(W1), .IMG_HEIGHT(H1), .DECIM(D1)) dut1 (
        .pclk(pclk), .reset(reset), .arm(arm1), .continuous(cont1), .fmt(fmt),
        .href(href), .vsync(vsync), .data(data), .we(we1), .wAddr(wAddr1),
        .wData(wData1), .busy(busy1), .frame_done(frame_done1), .frame_err(frame_err1));

    ov7670_frame_capture #(.IMG_WIDTH(W2), .IMG_HEIGHT(H2), .DECIM(D2)) dut2 (
        .pclk(pclk), .reset(reset), .arm(arm2), .continuous(cont2), .fmt(fmt),
        .href(href), .vsync(vsync), .data(data), .we(we2), .wAddr(wAddr2),
        .wData(wData2), .busy(busy2), .frame_done(frame_done2), .frame_err(frame_err2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [23:0] exp_pix(input logic f, input logic [7:0] h, input logic [7:0] l);
        return f ? {h, h, h} : {h[7:3], 3'b000, h[2:0], l[7:5], 2'b00, l[4:0], 3'b000};
    endfunction

    always @(negedge pclk) begin
        if (we1) begin
            if (q1.size() == 0) chk("w1_unexp", {31'b0, we1}, 32'd0);
            else begin
                e1 = q1.pop_front();
                chk("w1_addr", 32'(wAddr1), e1[55:24]);
                chk("w1_data", 32'(wData1), 32'(e1[23:0]));
            end
        end
        if (frame_done1) begin
            if (dq1.size() == 0) chk("done1_unexp", {31'b0, frame_done1}, 32'd0);
            else chk("err1", {31'b0, frame_err1}, {31'b0, dq1.pop_front()});
        end
        if (frame_err1 && !frame_done1) chk("err1_nodone", {31'b0, frame_done1}, 32'd1);
    end

    always @(negedge pclk) begin
        if (we2) begin
            if (q2.size() == 0) chk("w2_unexp", {31'b0, we2}, 32'd0);
            else begin
                e2 = q2.pop_front();
                chk("w2_addr", 32'(wAddr2), e2[55:24]);
                chk("w2_data", 32'(wData2), 32'(e2[23:0]));
            end
        end
        if (frame_done2) begin
            if (dq2.size() == 0) chk("done2_unexp", {31'b0, frame_done2}, 32'd0);
            else chk("err2", {31'b0, frame_err2}, {31'b0, dq2.pop_front()});
        end
        if (frame_err2 && !frame_done2) chk("err2_nodone", {31'b0, frame_done2}, 32'd1);
    end

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic arm_pulse(input int tgt, input logic c);
        if (tgt == 1) begin cont1 = c; arm1 = 1'b1; end
        else          begin cont2 = c; arm2 = 1'b1; end
        cyc();
        arm1 = 1'b0;
        arm2 = 1'b0;
    endtask

    // Drives one frame and, when expect_en, queues what the target should write.
    task automatic frame(input int tgt, input int lines, input int npix, input bit odd,
                         input logic [7:0] b0, input logic [7:0] b1, input bit fmtv,
                         input bit vary, input bit expect_en, input bit arm_mid,
                         input int rst_line);
        int w, h, d, total, cnt, nbytes;
        bit ovf, live;
        logic [7:0] hv, lv;
        w = (tgt == 1) ? W1 : W2;
        h = (tgt == 1) ? H1 : H2;
        d = (tgt == 1) ? D1 : D2;
        total = (w / d) * (h / d);
        cnt = 0;
        ovf = 0;
        live = expect_en;
        nbytes = 2 * npix + (odd ? 1 : 0);
        fmt = fmtv;
        vsync = 1'b0;
        repeat (3) cyc();
        for (int y = 0; y < lines; y++) begin
            href = 1'b1;
            for (int b = 0; b < nbytes; b++) begin
                if (y == rst_line && b == 4 && tgt == 2) begin
                    chk("rst_we",    {31'b0, we2}, 32'd0);
                    chk("rst_addr",  32'(wAddr2), 32'd0);
                    chk("rst_data",  32'(wData2), 32'd0);
                    chk("rst_busy",  {31'b0, busy2}, 32'd0);
                    chk("rst_done",  {31'b0, frame_done2}, 32'd0);
                end
                hv = vary ? (b0 ^ 8'(b / 2) ^ 8'(y << 4)) : b0;
                lv = vary ? (b1 ^ 8'((b / 2) * 8)) : b1;
                data = (b % 2 == 0) ? hv : lv;
                if (arm_mid && y == 0 && b == 2) begin
                    if (tgt == 1) arm1 = 1'b1; else arm2 = 1'b1;
                end
                if (y == rst_line && b == 3) begin
                    reset = 1'b1;
                    live = 0;
                end
                if (b % 2 == 1 && live) begin
                    if ((b / 2) % d == 0 && y % d == 0) begin
                        if ((b / 2) < w && y < h && cnt < total) begin
                            if (tgt == 1) q1.push_back({32'(cnt), exp_pix(fmtv, hv, lv)});
                            else          q2.push_back({32'(cnt), exp_pix(fmtv, hv, lv)});
                            cnt++;
                        end else ovf = 1;
                    end
                end
                cyc();
                arm1 = 1'b0;
                arm2 = 1'b0;
                reset = 1'b0;
            end
            href = 1'b0;
            repeat (3) cyc();
        end
        vsync = 1'b1;
        if (live) begin
            if (tgt == 1) dq1.push_back(ovf || cnt != total);
            else          dq2.push_back(ovf || cnt != total);
        end
        repeat (6) cyc();
    endtask

    task automatic drain(input string tag);
        repeat (4) cyc();
        chk({tag, "_q1"},  q1.size(),  32'd0);
        chk({tag, "_q2"},  q2.size(),  32'd0);
        chk({tag, "_dq1"}, dq1.size(), 32'd0);
        chk({tag, "_dq2"}, dq2.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; fmt = 1'b0; href = 1'b0; vsync = 1'b1; data = 8'h00;
        arm1 = 1'b0; cont1 = 1'b0; arm2 = 1'b0; cont2 = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("r_we1",   {31'b0, we1}, 32'd0);
        chk("r_addr1", 32'(wAddr1), 32'd0);
        chk("r_data1", 32'(wData1), 32'd0);
        chk("r_busy1", {31'b0, busy1}, 32'd0);
        chk("r_done1", {31'b0, frame_done1}, 32'd0);
        chk("r_err1",  {31'b0, frame_err1}, 32'd0);
        chk("r_busy2", {31'b0, busy2}, 32'd0);
        chk("r_addr2", 32'(wAddr2), 32'd0);

        // RGB565 4x2 at full rate, then with varying pixel values
        arm_pulse(1, 1'b0);
        chk("arm_busy1", {31'b0, busy1}, 32'd1);
        frame(1, 2, 4, 0, 8'hF8, 8'h00, 1'b0, 0, 1, 0, -1);
        drain("t1");
        chk("t1_idle", {31'b0, busy1}, 32'd0);
        arm_pulse(1, 1'b0);
        frame(1, 2, 4, 0, 8'h5A, 8'hC3, 1'b0, 1, 1, 0, -1);
        drain("t1v");

        // YUV422 8x4 decimated by 2
        arm_pulse(2, 1'b0);
        frame(2, 4, 8, 0, 8'h80, 8'h10, 1'b1, 0, 1, 0, -1);
        drain("t2");
        arm_pulse(2, 1'b0);
        frame(2, 4, 8, 0, 8'h37, 8'hE1, 1'b0, 1, 1, 0, -1);
        drain("t2v");

        // Arm mid-frame: nothing until the next frame start
        frame(2, 4, 8, 0, 8'h11, 8'h22, 1'b0, 1, 0, 1, -1);
        chk("t3_wait", {31'b0, busy2}, 32'd1);
        frame(2, 4, 8, 0, 8'h44, 8'h99, 1'b1, 1, 1, 0, -1);
        drain("t3");

        // Short then long frame
        arm_pulse(2, 1'b0);
        frame(2, 2, 8, 0, 8'h66, 8'h77, 1'b0, 1, 1, 0, -1);
        drain("t4s");
        arm_pulse(2, 1'b0);
        frame(2, 6, 9, 0, 8'hA5, 8'h3C, 1'b0, 1, 1, 0, -1);
        drain("t4l");

        // Odd trailing byte on every line
        arm_pulse(2, 1'b0);
        frame(2, 4, 8, 1, 8'h2B, 8'hD4, 1'b0, 1, 1, 0, -1);
        drain("t6o");

        // Continuous: three back-to-back frames
        arm_pulse(2, 1'b1);
        cont2 = 1'b0;
        for (int f = 0; f < 3; f++) begin
            frame(2, 4, 8, 0, 8'(8'h10 + f * 8'h20), 8'h0F, f[0], 1, 1, 0, -1);
            chk("t5_busy", {31'b0, busy2}, 32'd1);
        end
        drain("t5");

        // Reset mid-line while still continuous, then an unarmed frame
        frame(2, 4, 8, 1, 8'hC6, 8'h39, 1'b0, 1, 1, 0, 1);
        chk("t6_idle", {31'b0, busy2}, 32'd0);
        frame(2, 4, 8, 0, 8'h12, 8'h34, 1'b0, 1, 0, 0, -1);
        drain("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
